// File: rtl/output_merger_pkg.sv
// Shared definitions for the 2:1 packet output merger: framing state
// encodings and default widths used by the top level and the per-port framer.
package output_merger_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int CTRL_WIDTH_DEF = DATA_WIDTH_DEF / 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HDR  = 2'b01,
    S_BODY = 2'b10
  } frame_state_e;

endpackage

// File: rtl/output_merger_pkt_framer.sv
// Per-port packet framing tracker. Follows accepted words through
// IDLE -> HDR -> BODY -> IDLE, flags the end-of-packet word and counts
// completed packets (wrapping counter).
module pkt_framer
  import output_merger_pkg::*;
#(
  parameter int CTRL_WIDTH = CTRL_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_acc,
  input  logic [CTRL_WIDTH-1:0] ctrl,
  output logic [1:0]            state,
  output logic                  eop,
  output logic [CNT_WIDTH-1:0]  pkt_cnt
);

  frame_state_e         state_q;
  frame_state_e         state_nxt;
  logic [CNT_WIDTH-1:0] pkt_cnt_q;

  // Next framing state and EOP detect; only accepted words move the FSM
  always_comb begin
    state_nxt = state_q;
    eop       = 1'b0;
    if (wr_acc) begin
      case (state_q)
        S_IDLE: if (ctrl != '0) state_nxt = S_HDR;
        S_HDR:  if (ctrl == '0) state_nxt = S_BODY;
        S_BODY: begin
          if (ctrl != '0) begin
            state_nxt = S_IDLE;
            eop       = 1'b1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register and completed-packet counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_nxt;
      if (eop) begin
        pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign state   = state_q;
  assign pkt_cnt = pkt_cnt_q;

endmodule

// File: rtl/output_merger.sv
// Packet-granular 2:1 merger. One upstream port owns the output at a time;
// ownership only moves at packet boundaries and alternates between requesters,
// so packets from the two engines are never interleaved on the output.
module output_merger
  import output_merger_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data0,
  input  logic [CTRL_WIDTH-1:0] in_ctrl0,
  input  logic                  in_wr0,
  input  logic                  in_req0,
  output logic                  in_rdy0,
  input  logic [DATA_WIDTH-1:0] in_data1,
  input  logic [CTRL_WIDTH-1:0] in_ctrl1,
  input  logic                  in_wr1,
  input  logic                  in_req1,
  output logic                  in_rdy1,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  grant,
  output logic                  lock,
  output logic [1:0]            state0,
  output logic [1:0]            state1,
  output logic [CNT_WIDTH-1:0]  pkt_cnt0,
  output logic [CNT_WIDTH-1:0]  pkt_cnt1,
  output logic                  drop_err
);

  logic                  wr_acc0;
  logic                  wr_acc1;
  logic                  eop0;
  logic                  eop1;
  logic                  acc_g;
  logic                  eop_g;
  logic [1:0]            state_g;
  logic [DATA_WIDTH-1:0] data_g;
  logic [CTRL_WIDTH-1:0] ctrl_g;
  logic                  other_req;
  logic                  drop;

  // Only the granted port sees ready; held low while reset is asserted
  assign in_rdy0 = ~grant & out_rdy & reset;
  assign in_rdy1 =  grant & out_rdy & reset;

  assign wr_acc0 = in_wr0 & in_rdy0;
  assign wr_acc1 = in_wr1 & in_rdy1;

  pkt_framer #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_framer0 (
    .clk     (clk),
    .reset   (reset),
    .wr_acc  (wr_acc0),
    .ctrl    (in_ctrl0),
    .state   (state0),
    .eop     (eop0),
    .pkt_cnt (pkt_cnt0)
  );

  pkt_framer #(
    .CTRL_WIDTH (CTRL_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_framer1 (
    .clk     (clk),
    .reset   (reset),
    .wr_acc  (wr_acc1),
    .ctrl    (in_ctrl1),
    .state   (state1),
    .eop     (eop1),
    .pkt_cnt (pkt_cnt1)
  );

  // Select the granted port's view and decide whether it is mid-packet
  always_comb begin
    acc_g     = grant ? wr_acc1  : wr_acc0;
    eop_g     = grant ? eop1     : eop0;
    state_g   = grant ? state1   : state0;
    data_g    = grant ? in_data1 : in_data0;
    ctrl_g    = grant ? in_ctrl1 : in_ctrl0;
    other_req = grant ? in_req0  : in_req1;
    drop      = grant ? in_wr0   : in_wr1;
    if (acc_g) begin
      lock = ~eop_g;
    end else begin
      lock = (state_g != S_IDLE);
    end
  end

  // Round-robin grant, re-arbitrated only at a packet boundary
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant <= 1'b0;
    end else if (!lock && other_req) begin
      grant <= ~grant;
    end
  end

  // Output register stage plus the dropped-write pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
      drop_err <= 1'b0;
    end else begin
      out_wr   <= acc_g;
      drop_err <= drop;
      if (acc_g) begin
        out_data <= data_g;
        out_ctrl <= ctrl_g;
      end
    end
  end

endmodule

// File: tb/tb_output_merger.sv
// Scoreboard bench for output_merger: expected words are queued as they are
// driven (or in the required arbitration order) and compared as they emerge.
module tb_output_merger;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NW = 16;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data0, in_data1;
  logic [CW-1:0] in_ctrl0, in_ctrl1;
  logic          in_wr0, in_wr1, in_req0, in_req1;
  logic          in_rdy0, in_rdy1;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic          out_wr, out_rdy, grant, lock, drop_err;
  logic [1:0]    state0, state1;
  logic [NW-1:0] pkt_cnt0, pkt_cnt1;

  typedef struct {
    logic [71:0] word;
    int          cyc;
  } sb_entry_t;

  sb_entry_t     sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            burst_first = -1;
  int            burst_last = -1;
  logic [NW-1:0] exp_cnt0 = '0;
  logic [NW-1:0] exp_cnt1 = '0;

  output_merger #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
    .clk(clk), .reset(reset),
    .in_data0(in_data0), .in_ctrl0(in_ctrl0), .in_wr0(in_wr0), .in_req0(in_req0), .in_rdy0(in_rdy0),
    .in_data1(in_data1), .in_ctrl1(in_ctrl1), .in_wr1(in_wr1), .in_req1(in_req1), .in_rdy1(in_rdy1),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .grant(grant), .lock(lock), .state0(state0), .state1(state1),
    .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .drop_err(drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  task automatic checkOutput(input string tag, input logic [79:0] actual, input logic [79:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [DW-1:0] mkData(input int port, input int pkt, input int idx);
    return {8'hD0, 32'h0, port[7:0], pkt[7:0], idx[7:0]};
  endfunction

  function automatic logic [CW-1:0] mkCtrl(input int idx, input int n, input int nhdr);
    if (idx < nhdr) return 8'hFF;
    if (idx == n - 1) return 8'h01;
    return 8'h00;
  endfunction

  // Output monitor: every out_wr must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset === 1'b1 && out_wr === 1'b1) begin
      if (burst_first < 0) burst_first = cycle;
      burst_last = cycle;
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", sb.size(), 1);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput("out_word", {out_ctrl, out_data}, e.word);
        if (e.cyc >= 0) checkOutput("latency", cycle - e.cyc, 1);
      end
    end
  end

  // Drive one word on a port once it is ready; returns at posedge+1
  task automatic applyStimulus(input int port, input logic [DW-1:0] d, input logic [CW-1:0] c, input bit push);
    int budget = 0;
    sb_entry_t e;
    @(negedge clk);
    while (((port == 0) ? in_rdy0 : in_rdy1) !== 1'b1 && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (((port == 0) ? in_rdy0 : in_rdy1) === 1'b1) begin
      if (port == 0) begin
        in_data0 = d; in_ctrl0 = c; in_wr0 = 1'b1;
      end else begin
        in_data1 = d; in_ctrl1 = c; in_wr1 = 1'b1;
      end
      if (push) begin
        e.word = {c, d};
        e.cyc  = cycle;
        sb.push_back(e);
      end
    end else begin
      checkOutput("rdy_timeout", budget, 0);
    end
    @(posedge clk);
    #1;
    if (port == 0) in_wr0 = 1'b0; else in_wr1 = 1'b0;
  endtask

  task automatic sendFrame(input int port, input int pkt, input int n, input int nhdr, input bit push);
    if (port == 0) in_req0 = 1'b1; else in_req1 = 1'b1;
    for (int i = 0; i < n; i++) applyStimulus(port, mkData(port, pkt, i), mkCtrl(i, n, nhdr), push);
    if (port == 0) begin
      in_req0 = 1'b0; exp_cnt0 = exp_cnt0 + 1'b1;
    end else begin
      in_req1 = 1'b0; exp_cnt1 = exp_cnt1 + 1'b1;
    end
  endtask

  task automatic waitDrain();
    int w = 0;
    @(negedge clk);
    #1;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    checkOutput("sb_drain", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b0; out_rdy = 1'b1;
    in_data0 = '0; in_ctrl0 = '0; in_wr0 = 1'b0; in_req0 = 1'b0;
    in_data1 = '0; in_ctrl1 = '0; in_wr1 = 1'b0; in_req1 = 1'b0;
    #12;
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_state0", state0, 0);
    checkOutput("rst_state1", state1, 0);
    checkOutput("rst_cnt0", pkt_cnt0, 0);
    checkOutput("rst_cnt1", pkt_cnt1, 0);
    checkOutput("rst_out", {out_wr, out_ctrl, out_data}, 0);
    checkOutput("rst_drop", drop_err, 0);
    checkOutput("rst_rdy0", in_rdy0, 0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // single 6-word packet on port 0 with two header words
    sendFrame(0, 0, 6, 2, 1'b1);
    waitDrain();
    checkOutput("t1_cnt0", pkt_cnt0, exp_cnt0);
    checkOutput("t1_grant", grant, 0);
    checkOutput("t1_state0", state0, 0);

    // both ports requesting, expected order fixed as P0,P1,P0,P1
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        sb_entry_t e;
        e.word = {mkCtrl(i, 4, 1), mkData(k % 2, k / 2, i)};
        e.cyc  = -1;
        sb.push_back(e);
      end
    end
    burst_first = -1;
    @(posedge clk); #1;
    fork
      begin sendFrame(0, 0, 4, 1, 1'b0); sendFrame(0, 1, 4, 1, 1'b0); end
      begin sendFrame(1, 0, 4, 1, 1'b0); sendFrame(1, 1, 4, 1, 1'b0); end
    join
    waitDrain();
    checkOutput("t2_no_bubble", burst_last - burst_first + 1, 16);
    checkOutput("t2_cnt0", pkt_cnt0, exp_cnt0);
    checkOutput("t2_cnt1", pkt_cnt1, exp_cnt1);

    // downstream stall for three cycles in the middle of a body
    in_req0 = 1'b1;
    applyStimulus(0, mkData(0, 2, 0), 8'hFF, 1'b1);
    applyStimulus(0, mkData(0, 2, 1), 8'h00, 1'b1);
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t3_stall_rdy0", in_rdy0, 0);
      if (i > 0) checkOutput("t3_stall_wr", out_wr, 0);
    end
    checkOutput("t3_state0_body", state0, 2);
    checkOutput("t3_lock", lock, 1);
    @(posedge clk); #1;
    out_rdy = 1'b1;
    applyStimulus(0, mkData(0, 2, 2), 8'h00, 1'b1);
    applyStimulus(0, mkData(0, 2, 3), 8'h01, 1'b1);
    in_req0 = 1'b0; exp_cnt0 = exp_cnt0 + 1'b1;
    waitDrain();
    checkOutput("t3_cnt0", pkt_cnt0, exp_cnt0);

    // port 1 writes without grant while port 0 sends a header
    in_req0 = 1'b1;
    fork
      applyStimulus(0, mkData(0, 3, 0), 8'hFF, 1'b1);
      begin
        @(negedge clk);
        in_data1 = 64'hBAD0_BAD0_BAD0_BAD0; in_ctrl1 = 8'hFF; in_wr1 = 1'b1;
        @(posedge clk); #1;
        in_wr1 = 1'b0;
      end
    join
    @(negedge clk);
    checkOutput("t4_drop_pulse", drop_err, 1);
    checkOutput("t4_state1", state1, 0);
    @(negedge clk);
    checkOutput("t4_drop_clear", drop_err, 0);
    applyStimulus(0, mkData(0, 3, 1), 8'h00, 1'b1);
    applyStimulus(0, mkData(0, 3, 2), 8'h01, 1'b1);
    in_req0 = 1'b0; exp_cnt0 = exp_cnt0 + 1'b1;
    waitDrain();
    checkOutput("t4_cnt0", pkt_cnt0, exp_cnt0);
    checkOutput("t4_cnt1", pkt_cnt1, exp_cnt1);

    // reset asserted while port 0 is in BODY
    in_req0 = 1'b1;
    applyStimulus(0, mkData(0, 4, 0), 8'hFF, 1'b1);
    applyStimulus(0, mkData(0, 4, 1), 8'h00, 1'b1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("t5_out", {out_wr, out_ctrl, out_data}, 0);
    checkOutput("t5_state0", state0, 0);
    checkOutput("t5_cnt0", pkt_cnt0, 0);
    checkOutput("t5_grant", grant, 0);
    checkOutput("t5_rdy0", in_rdy0, 0);
    checkOutput("t5_lock", lock, 0);
    in_req0 = 1'b0; exp_cnt0 = '0; exp_cnt1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    sendFrame(0, 5, 5, 1, 1'b1);
    waitDrain();
    checkOutput("t5_cnt0_after", pkt_cnt0, exp_cnt0);
    checkOutput("t5_state0_after", state0, 0);

    // port 1 counter wraps from all-ones to zero
    @(posedge clk); #1;
    force dut.u_framer1.pkt_cnt_q = 16'hFFFF;
    #1 release dut.u_framer1.pkt_cnt_q;
    exp_cnt1 = 16'hFFFF;
    @(negedge clk);
    checkOutput("t6_preload", pkt_cnt1, exp_cnt1);
    @(posedge clk); #1;
    sendFrame(1, 6, 4, 1, 1'b1);
    waitDrain();
    checkOutput("t6_wrap", pkt_cnt1, exp_cnt1);
    checkOutput("t6_grant", grant, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
